mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Write-back stage directly downstream of the memory stage.
- Captures the memory-stage result into the MEM/WB pipeline register. Selects between ALU result and load data, and extracts/extends sub-word loads from the 32-bit word returned by the data cache.
- Drives the register-file write port and the WB forwarding path.
- Inserts a bubble while the memory stage reports stall, so the instruction in WB retires exactly once.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- m_valid  in  1  memory stage holds a real instruction
- m_stall  in  1  memory stage stall (cs & ~ack); MEM instruction not complete this cycle
- m_alu_out  in  32  ALU result / effective address from EX/MEM
- m_d  in  32  word read data from the data cache, valid when m_stall=0
- m_rmem  in  1  instruction is a load
- m_wreg  in  1  instruction writes a register
- m_wn  in  5  destination register number
- m_ld_type  in  3  0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU; 5..7 treated as LW
- wb_valid  out  1  WB register holds a retiring instruction
- wb_we  out  1  register-file write enable
- wb_wn  out  5  register-file write address
- wb_data  out  32  register-file write data; also the WB forwarding value
- wb_misalign  out  1  the retiring load was misaligned (write suppressed)

Behaviour:
- Reset (async, rst=1): wb_valid, wb_we, wb_misalign = 0; wb_wn = 0; wb_data = 0. All outputs stay at these values while rst is high.
- Latency: one cycle. Inputs sampled at a rising edge appear on the outputs after that edge. Outputs come directly from registers with no combinational path from inputs.
- Capture condition `cap = m_valid & ~m_stall`.
- If cap=0 at an edge, load a bubble: wb_valid=0, wb_we=0, wb_misalign=0. wb_wn and wb_data hold their previous values. The previous WB instruction still retires; no back-pressure exists from WB.
- Byte offset `off = m_alu_out[1:0]`. Memory is little-endian, so byte k occupies m_d[8k+7:8k].
- Load data by type:
  - LW: m_d.
  - LB/LBU: selected byte, sign-extended (LB) or zero-extended (LBU).
  - LH/LHU: halfword at off[1] (off=0 → m_d[15:0], off=2 → m_d[31:16]), sign- or zero-extended.
- Misalignment applies to loads only (m_rmem=1):
  - LW with off≠0, or LH/LHU with off[0]=1, is misaligned.
  - Set wb_misalign=1 and wb_we=0.
  - wb_data = raw m_d; it is only observable, not written.
- Result select: wb_data = load data if m_rmem=1, else m_alu_out.
- Write enable: wb_we = cap & m_wreg & (m_wn≠0) & ~misaligned. Register 0 is never written.
- wb_valid = cap. A store (m_wreg=0) retires with wb_valid=1, wb_we=0.
- Stall boundary: during a multi-cycle cache miss, WB shows bubbles each stalled cycle. The load appears once, in the cycle after ack.
- Reset mid-stall: outputs clear immediately. After rst deasserts, the first capture occurs at the first edge with cap=1.

Optional Feature:
- Macro WB_PERF_CNT_EN.
- Defined: adds outputs perf_retired (32) and perf_stall (32).
  - perf_retired increments at each edge with cap=1.
  - perf_stall increments at each edge with m_valid & m_stall.
  - Both reset to 0 and wrap modulo 2^32.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- ALU write: m_valid=1, m_stall=0, m_rmem=0, m_wreg=1, m_wn=5, m_alu_out=0x1234_5678 → next cycle wb_valid=1, wb_we=1, wb_wn=5, wb_data=0x1234_5678.
- Sub-word loads, m_d=0x80FF_7F01:
  - LB, m_alu_out=0x...3 → wb_data=0xFFFF_FF80.
  - LBU, off=1 → 0x0000_007F.
  - LH, off=2 → 0xFFFF_80FF.
  - LHU, off=0 → 0x0000_7F01.
- Cache miss: load with m_stall=1 for 3 cycles then 0, m_d=0xDEAD_BEEF, LW, m_wn=9 → wb_valid=0 for 3 cycles, then exactly one cycle wb_we=1, wb_wn=9, wb_data=0xDEAD_BEEF.
- r0 and store: m_wreg=1, m_wn=0 → wb_valid=1, wb_we=0; store with m_wreg=0 → wb_valid=1, wb_we=0.
- Misaligned: LW at m_alu_out=0x0000_0102 → wb_misalign=1, wb_we=0; following aligned LW → wb_misalign=0.
- Reset mid-stall: assert rst asynchronously between edges while wb_we=1 → wb_we, wb_valid, wb_data go to 0 immediately without a clock edge. With WB_PERF_CNT_EN defined, counters read 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM/WB pipeline register. Selects between the ALU result and
//            extended load data, and drives the register-file write port.
//            Defining WB_PERF_CNT_EN adds retired and stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_valid,
    input  logic              m_stall,
    input  logic [DATA_W-1:0] m_alu_out,
    input  logic [DATA_W-1:0] m_d,
    input  logic              m_rmem,
    input  logic              m_wreg,
    input  logic [REG_AW-1:0] m_wn,
    input  logic [2:0]        m_ld_type,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_wn,
    output logic [DATA_W-1:0] wb_data,
`ifdef WB_PERF_CNT_EN
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_stall,
`endif
    output logic              wb_misalign
);

    localparam logic [2:0] c_LD_LB  = 3'd1;
    localparam logic [2:0] c_LD_LBU = 3'd2;
    localparam logic [2:0] c_LD_LH  = 3'd3;
    localparam logic [2:0] c_LD_LHU = 3'd4;

    logic              w_cap;
    logic [1:0]        w_off;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load_data;
    logic              w_misaligned;
    logic [DATA_W-1:0] w_result;
    logic              w_we;

    logic              r_valid;
    logic              r_we;
    logic              r_misalign;
    logic [REG_AW-1:0] r_wn;
    logic [DATA_W-1:0] r_data;

    assign w_cap = m_valid & ~m_stall;
    assign w_off = m_alu_out[1:0];

    // Little-endian lane select: byte k lives in m_d[8k+7:8k].
    always_comb begin
        w_byte = m_d[7:0];
        case (w_off)
            2'd0: w_byte = m_d[7:0];
            2'd1: w_byte = m_d[15:8];
            2'd2: w_byte = m_d[23:16];
            2'd3: w_byte = m_d[31:24];
            default: w_byte = m_d[7:0];
        endcase
        w_half = w_off[1] ? m_d[31:16] : m_d[15:0];
    end

    // Types 5..7 fall into the word path and are handled exactly like LW.
    always_comb begin
        w_load_data  = m_d;
        w_misaligned = 1'b0;
        case (m_ld_type)
            c_LD_LB:  w_load_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            c_LD_LBU: w_load_data = {{(DATA_W-8){1'b0}}, w_byte};
            c_LD_LH: begin
                w_load_data  = {{(DATA_W-16){w_half[15]}}, w_half};
                w_misaligned = w_off[0];
            end
            c_LD_LHU: begin
                w_load_data  = {{(DATA_W-16){1'b0}}, w_half};
                w_misaligned = w_off[0];
            end
            default: begin
                w_load_data  = m_d;
                w_misaligned = (w_off != 2'd0);
            end
        endcase
        // A misaligned load exposes the raw word; it is never written back.
        if (w_misaligned) begin
            w_load_data = m_d;
        end
    end

    assign w_result = m_rmem ? w_load_data : m_alu_out;
    assign w_we     = w_cap & m_wreg & (m_wn != '0) & ~(m_rmem & w_misaligned);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_we       <= 1'b0;
            r_misalign <= 1'b0;
            r_wn       <= '0;
            r_data     <= '0;
        end else if (w_cap) begin
            r_valid    <= 1'b1;
            r_we       <= w_we;
            r_misalign <= m_rmem & w_misaligned;
            r_wn       <= m_wn;
            r_data     <= w_result;
        end else begin
            // Bubble: the WB address/data hold so the forwarding value stays stable.
            r_valid    <= 1'b0;
            r_we       <= 1'b0;
            r_misalign <= 1'b0;
        end
    end

    assign wb_valid    = r_valid;
    assign wb_we       = r_we;
    assign wb_misalign = r_misalign;
    assign wb_wn       = r_wn;
    assign wb_data     = r_data;

`ifdef WB_PERF_CNT_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_retired <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_cap) begin
                r_perf_retired <= r_perf_retired + 32'd1;
            end
            if (m_valid & m_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
`default_nettype wire
